// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite line engine: video timing,
// attribute byte layout, FSM states and the slot record.
package sprite_pkg;

   localparam int HACTIVE = 1280;
   localparam int HEVAL   = 1312;
   localparam int HTOTAL  = 1600;
   localparam int VACTIVE = 480;
   localparam int VTOTAL  = 525;

   localparam int ATTR_Y     = 0;
   localparam int ATTR_X     = 1;
   localparam int ATTR_PAT   = 2;
   localparam int ATTR_FLAGS = 3;

   localparam int FLAG_XHI_LSB = 0;
   localparam int FLAG_YHI     = 2;
   localparam int FLAG_EN      = 7;

   // Row width carried by a slot record (SPR_W*BPP of the engine build).
   localparam int SLOT_ROW_W = 64;

   typedef enum logic [1:0] {IDLE, EVAL, FETCH, DONE} state_t;

   typedef struct packed {
      logic                  valid;
      logic [9:0]            x;
      logic [SLOT_ROW_W-1:0] row;
   } slot_t;

endpackage

// File: rtl/sprite_line_engine_if.sv
// Read bus between the sprite engine and its attribute and generator RAMs.
// Both RAMs return data one clock after the address is presented.
interface sprite_line_engine_if #(
   parameter int ATTR_AW = 5,
   parameter int GEN_AW  = 11
);
   logic [ATTR_AW-1:0] attr_ra;
   logic [7:0]         attr_dout;
   logic [GEN_AW-1:0]  gen_ra;
   logic [7:0]         gen_dout;

   modport master (output attr_ra, output gen_ra, input attr_dout, input gen_dout);
   modport slave  (input attr_ra, input gen_ra, output attr_dout, output gen_dout);
endinterface

// File: rtl/sprite_slot.sv
// One active sprite slot: given the current column, returns the slot's pixel
// nibble and whether it is an opaque hit. Columns left of x never hit, and
// columns past 639 never occur, so a sprite near the right edge is clipped.
module sprite_slot
   import sprite_pkg::*;
#(
   parameter int SPR_W = 16,
   parameter int BPP   = 4
)(
   input  slot_t          slot,
   input  logic [9:0]     col,
   output logic [BPP-1:0] nibble,
   output logic           hit
);
   localparam int PW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

   logic [9:0]    offs;
   logic [PW-1:0] px;
   logic          in_range;

   // Locate the column inside the sprite; the leftmost pixel sits in the top bits
   always_comb begin
      offs     = col - slot.x;
      in_range = slot.valid && (col >= slot.x) && (offs < 10'(SPR_W));
      px       = offs[PW-1:0];
      nibble   = slot.row[(SLOT_ROW_W - BPP) - int'(px) * BPP +: BPP];
      hit      = in_range && (nibble != '0);
   end
endmodule

// File: rtl/sprite_line_engine.sv
// Multi-sprite line engine. In horizontal blanking it scans the attribute
// table for sprites on the next line and fetches their pixel rows into
// shadow slots; at the end of the line the shadow set becomes the active set
// that is drawn with lowest-index priority.
// Optional build macro SPRITE_COLLISION_EN adds collision / collision_mask.
module sprite_line_engine
   import sprite_pkg::*;
#(
   parameter int N_SPRITES    = 8,
   parameter int MAX_PER_LINE = 4,
   parameter int SPR_W        = 16,
   parameter int SPR_H        = 16,
   parameter int BPP          = 4,
   parameter int GEN_AW       = 11
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [10:0]           hcount,
   input  logic [9:0]            vcount,
   sprite_line_engine_if.master  mem,
   output logic [BPP-1:0]        pix_code,
   output logic                  line_overflow,
   output logic                  busy
`ifdef SPRITE_COLLISION_EN
   ,
   output logic                  collision,
   output logic [N_SPRITES-1:0]  collision_mask
`endif
);
   localparam int BPR     = SPR_W * BPP / 8;
   localparam int ROW_W   = SPR_W * BPP;
   localparam int IDX_W   = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
   localparam int SLOT_W  = $clog2(MAX_PER_LINE + 1);
   localparam int SEL_W   = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
   localparam int FCNT_W  = $clog2(BPR + 1);
   localparam int ROWS_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   generate
      if (N_SPRITES * 5 + MAX_PER_LINE * (BPR + 2) > 280) begin : g_budget
         $error("sprite evaluation and fetch do not fit in horizontal blanking");
      end
      if (ROW_W != SLOT_ROW_W) begin : g_row_width
         $error("slot row width does not match SPR_W*BPP");
      end
   endgenerate

   state_t              state, next_state;
   logic [IDX_W-1:0]    idx;
   logic [2:0]          ecnt;
   logic [FCNT_W-1:0]   fcnt;
   logic [7:0]          y_lo, x_lo, pat;
   logic [9:0]          cur_x;
   logic [7:0]          cur_pat;
   logic [ROWS_W-1:0]   cur_row;
   logic [ROW_W-1:0]    row_buf, row_next;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [SEL_W-1:0]    slot_sel;
   logic                shadow_ovf;
   slot_t               shadow [MAX_PER_LINE];
   slot_t               active [MAX_PER_LINE];

   logic [9:0]          tline, spr_y, dy;
   logic                visible, slot_free, take_slot, last_sprite;
   logic [GEN_AW-1:0]   gen_addr;

   logic [9:0]          col;
   logic                active_region;
   logic [BPP-1:0]      slot_nib [MAX_PER_LINE];
   logic [MAX_PER_LINE-1:0] slot_hit;
   logic [BPP-1:0]      win;

   assign tline       = (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
   assign spr_y       = {1'b0, mem.attr_dout[FLAG_YHI], y_lo};
   assign dy          = tline - spr_y;
   assign visible     = mem.attr_dout[FLAG_EN] && (tline >= spr_y) && (dy < 10'(SPR_H));
   assign slot_free   = slot_cnt < SLOT_W'(MAX_PER_LINE);
   assign take_slot   = visible && slot_free;
   assign last_sprite = (idx == IDX_W'(N_SPRITES - 1));
   assign slot_sel    = slot_cnt[SEL_W-1:0];
   assign row_next    = {row_buf[ROW_W-9:0], mem.gen_dout};
   assign gen_addr    = GEN_AW'(cur_pat) * GEN_AW'(SPR_H * BPR)
                      + GEN_AW'(cur_row) * GEN_AW'(BPR) + GEN_AW'(fcnt);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next state, RAM addresses and busy; the end-of-line commit always returns to IDLE
   always_comb begin
      next_state  = state;
      mem.attr_ra = '0;
      mem.gen_ra  = '0;
      busy        = 1'b0;
      case (state)
         IDLE: if (hcount == 11'(HEVAL)) next_state = EVAL;
         EVAL: begin
            busy = 1'b1;
            if (ecnt != 3'd4)     mem.attr_ra = {idx, ecnt[1:0]};
            else if (take_slot)   next_state = FETCH;
            else if (last_sprite) next_state = DONE;
         end
         FETCH: begin
            busy       = 1'b1;
            mem.gen_ra = gen_addr;
            if (fcnt == FCNT_W'(BPR)) next_state = last_sprite ? DONE : EVAL;
         end
         DONE: ;
         default: next_state = IDLE;
      endcase
      if (hcount == 11'(HTOTAL - 1)) next_state = IDLE;
   end

`ifdef SPRITE_COLLISION_EN
   logic [IDX_W-1:0] shadow_idx [MAX_PER_LINE];
   logic [IDX_W-1:0] active_idx [MAX_PER_LINE];
`endif

   // Attribute evaluation, row fetch into shadow slots, and the end-of-line commit
   always_ff @(posedge clk) begin
      if (reset) begin
         idx           <= '0;
         ecnt          <= '0;
         fcnt          <= '0;
         y_lo          <= '0;
         x_lo          <= '0;
         pat           <= '0;
         cur_x         <= '0;
         cur_pat       <= '0;
         cur_row       <= '0;
         row_buf       <= '0;
         slot_cnt      <= '0;
         shadow_ovf    <= 1'b0;
         line_overflow <= 1'b0;
         for (int s = 0; s < MAX_PER_LINE; s++) begin
            shadow[s] <= '0;
            active[s] <= '0;
`ifdef SPRITE_COLLISION_EN
            shadow_idx[s] <= '0;
            active_idx[s] <= '0;
`endif
         end
      end else begin
         case (state)
            IDLE: begin
               if (hcount == 11'(HEVAL)) begin
                  idx      <= '0;
                  ecnt     <= '0;
                  slot_cnt <= '0;
               end
            end
            EVAL: begin
               case (ecnt)
                  3'd1:    y_lo <= mem.attr_dout;
                  3'd2:    x_lo <= mem.attr_dout;
                  3'd3:    pat  <= mem.attr_dout;
                  default: ;
               endcase
               if (ecnt == 3'd4) begin
                  ecnt <= '0;
                  if (take_slot) begin
                     cur_x   <= {mem.attr_dout[FLAG_XHI_LSB+1 -: 2], x_lo};
                     cur_pat <= pat;
                     cur_row <= dy[ROWS_W-1:0];
                     fcnt    <= '0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                     if (visible) shadow_ovf <= 1'b1;
                  end
               end else begin
                  ecnt <= ecnt + 3'd1;
               end
            end
            FETCH: begin
               if (fcnt != '0) row_buf <= row_next;
               if (fcnt == FCNT_W'(BPR)) begin
                  shadow[slot_sel] <= '{valid: 1'b1, x: cur_x, row: row_next};
`ifdef SPRITE_COLLISION_EN
                  shadow_idx[slot_sel] <= idx;
`endif
                  slot_cnt <= slot_cnt + SLOT_W'(1);
                  idx      <= idx + IDX_W'(1);
               end else begin
                  fcnt <= fcnt + FCNT_W'(1);
               end
            end
            default: ;
         endcase
         if (hcount == 11'(HTOTAL - 1)) begin
            for (int s = 0; s < MAX_PER_LINE; s++) begin
               active[s] <= (state == DONE) ? shadow[s] : '0;
               shadow[s] <= '0;
`ifdef SPRITE_COLLISION_EN
               active_idx[s] <= shadow_idx[s];
`endif
            end
            line_overflow <= (state == DONE) ? shadow_ovf : 1'b1;
            shadow_ovf    <= 1'b0;
         end
      end
   end

   assign col           = hcount[10:1];
   assign active_region = (hcount < 11'(HACTIVE)) && (vcount < 10'(VACTIVE));

   generate
      for (genvar s = 0; s < MAX_PER_LINE; s++) begin : g_slot
         sprite_slot #(.SPR_W(SPR_W), .BPP(BPP)) u_slot (
            .slot   (active[s]),
            .col    (col),
            .nibble (slot_nib[s]),
            .hit    (slot_hit[s])
         );
      end
   endgenerate

   // Priority mux: the lowest slot holds the lowest sprite index and wins
   always_comb begin
      win = '0;
      for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
         if (slot_hit[s]) win = slot_nib[s];
      end
   end

   // Registered pixel output, forced to background outside the visible area
   always_ff @(posedge clk) begin
      if (reset) pix_code <= '0;
      else       pix_code <= active_region ? win : '0;
   end

`ifdef SPRITE_COLLISION_EN
   logic [SLOT_W-1:0]    hit_count;
   logic [N_SPRITES-1:0] coll_bits;

   // Count opaque slots on this column and collect their sprite indices
   always_comb begin
      hit_count = '0;
      coll_bits = '0;
      for (int s = 0; s < MAX_PER_LINE; s++) begin
         if (slot_hit[s]) begin
            hit_count             = hit_count + SLOT_W'(1);
            coll_bits[active_idx[s]] = 1'b1;
         end
      end
   end

   // Sticky per-frame collision flags, cleared at the first pixel of the frame
   always_ff @(posedge clk) begin
      if (reset) begin
         collision      <= 1'b0;
         collision_mask <= '0;
      end else if (hcount == 11'd0 && vcount == 10'd0) begin
         collision      <= 1'b0;
         collision_mask <= '0;
      end else if (active_region && hit_count >= SLOT_W'(2)) begin
         collision      <= 1'b1;
         collision_mask <= collision_mask | coll_bits;
      end
   end
`endif

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed testbench for sprite_line_engine: behavioural attribute and
// generator RAMs, bench-driven hcount/vcount, hand-computed pixel codes.
module tb_sprite_line_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [3:0]  pix_code;
   logic        line_overflow;
   logic        busy;
`ifdef SPRITE_COLLISION_EN
   logic        collision;
   logic [7:0]  collision_mask;
`endif

   logic [7:0] attr_mem [32];
   logic [7:0] gen_mem  [2048];

   int checks   = 0;
   int failures = 0;

   sprite_line_engine_if #(.ATTR_AW(5), .GEN_AW(11)) bus ();

   sprite_line_engine dut (
      .clk           (clk),
      .reset         (reset),
      .hcount        (hcount),
      .vcount        (vcount),
      .mem           (bus),
      .pix_code      (pix_code),
      .line_overflow (line_overflow),
      .busy          (busy)
`ifdef SPRITE_COLLISION_EN
      ,
      .collision     (collision),
      .collision_mask(collision_mask)
`endif
   );

   // 50 MHz clock
   always #10 clk = ~clk;

   // Synchronous RAMs with one clock of read latency
   always @(posedge clk) begin
      bus.attr_dout <= attr_mem[bus.attr_ra];
      bus.gen_dout  <= gen_mem[bus.gen_ra];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One clock; inputs change 1 ns after the edge, counters wrap like the video timer
   task automatic stepClk();
      @(posedge clk);
      #1;
      if (hcount == 11'd1599) begin
         hcount = 11'd0;
         vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
      end else begin
         hcount = hcount + 11'd1;
      end
   endtask

   task automatic gotoH(input int target);
      int n = 0;
      while (hcount != 11'(target) && n < 3300) begin
         stepClk();
         n++;
      end
      if (hcount != 11'(target)) begin
         checks++;
         failures++;
         $display("[TB] FAIL gotoH observed=%0d expected=%0d", hcount, target);
      end
   endtask

   // Present hcount=h for one edge, then check the registered pixel for it
   task automatic checkPixH(input int h, input int expected, input string tag);
      gotoH(h);
      stepClk();
      checkOutput(tag, 32'(pix_code), 32'(expected));
   endtask

   task automatic checkPix(input int c, input int expected, input string tag);
      checkPixH(2 * c, expected, tag);
   endtask

   // Evaluate and commit line `vline`, ending at hcount=0 of that line
   task automatic applyStimulus(input int vline);
      vcount = (vline == 0) ? 10'd524 : 10'(vline - 1);
      hcount = 11'd1300;
      gotoH(0);
   endtask

   task automatic setSprite(input int i, input int y, input int x, input int p, input bit en);
      logic [8:0] yv;
      logic [9:0] xv;
      yv = 9'(y);
      xv = 10'(x);
      attr_mem[4*i]   = yv[7:0];
      attr_mem[4*i+1] = xv[7:0];
      attr_mem[4*i+2] = 8'(p);
      attr_mem[4*i+3] = {en, 4'b0000, yv[8], xv[9:8]};
   endtask

   task automatic clearSprites();
      for (int i = 0; i < 32; i++) attr_mem[i] = 8'h00;
   endtask

   task automatic fillPattern(input int p, input logic [7:0] b);
      for (int i = 0; i < 128; i++) gen_mem[p*128 + i] = b;
   endtask

   initial begin
      clearSprites();
      for (int i = 0; i < 2048; i++) gen_mem[i] = 8'h00;
      fillPattern(1, 8'h11);
      fillPattern(2, 8'h20);
      fillPattern(3, 8'h44);
      fillPattern(4, 8'h33);
      fillPattern(5, 8'h55);
      fillPattern(6, 8'h66);
      fillPattern(7, 8'h77);
      fillPattern(8, 8'h88);
      fillPattern(9, 8'h99);

      reset  = 1'b1;
      hcount = 11'd0;
      vcount = 10'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("rst_pix", 32'(pix_code), 0);
      checkOutput("rst_ovf", 32'(line_overflow), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_attr_ra", 32'(bus.attr_ra), 0);
      checkOutput("rst_gen_ra", 32'(bus.gen_ra), 0);
`ifdef SPRITE_COLLISION_EN
      checkOutput("rst_coll", 32'(collision), 0);
`endif

      $display("[TB] single sprite on line 10");
      setSprite(0, 10, 100, 1, 1'b1);
      vcount = 10'd9;
      hcount = 11'd1300;
      gotoH(1314);
      checkOutput("eval_busy", 32'(busy), 1);
      checkOutput("eval_attr_ra", 32'(bus.attr_ra), 1);
      gotoH(1500);
      checkOutput("done_busy", 32'(busy), 0);
      gotoH(0);
      checkOutput("l10_ovf", 32'(line_overflow), 0);
      checkPix(99, 0, "l10_col99");
      checkPix(100, 1, "l10_col100");
      checkPix(115, 1, "l10_col115");
      checkPix(116, 0, "l10_col116");

      $display("[TB] five sprites on line 20");
      clearSprites();
      for (int i = 0; i < 4; i++) setSprite(i, 20, 10 + 20*i, 5 + i, 1'b1);
      setSprite(4, 5, 90, 9, 1'b1);
      applyStimulus(20);
      checkOutput("l20_ovf", 32'(line_overflow), 1);
      checkPix(10, 5, "l20_spr0");
      checkPix(30, 6, "l20_spr1");
      checkPix(50, 7, "l20_spr2");
      checkPix(70, 8, "l20_spr3");
      checkPix(90, 0, "l20_spr4_absent");
      gotoH(0);
      checkOutput("l21_ovf", 32'(line_overflow), 0);
      checkPix(10, 5, "l21_spr0");
      checkPix(90, 0, "l21_col90");

      $display("[TB] overlapping sprites 1 and 3 on line 30");
      clearSprites();
      setSprite(1, 30, 200, 2, 1'b1);
      setSprite(3, 30, 200, 3, 1'b1);
      applyStimulus(30);
      checkPix(199, 0, "ovl_col199");
      checkPix(200, 2, "ovl_col200");
      checkPix(201, 4, "ovl_col201");
      checkPix(214, 2, "ovl_col214");
      checkPix(215, 4, "ovl_col215");
      checkPix(216, 0, "ovl_col216");
`ifdef SPRITE_COLLISION_EN
      checkOutput("ovl_coll", 32'(collision), 1);
      checkOutput("ovl_mask", 32'(collision_mask), 32'b1010);
`endif

      $display("[TB] sprite at y=0 fetched from line 524");
      clearSprites();
      setSprite(0, 0, 50, 4, 1'b1);
      applyStimulus(0);
      checkPix(49, 0, "l0_col49");
      checkPix(50, 3, "l0_col50");
      checkPix(65, 3, "l0_col65");
      checkPix(66, 0, "l0_col66");

      $display("[TB] sprite at x=630 is clipped");
      clearSprites();
      setSprite(0, 40, 630, 4, 1'b1);
      applyStimulus(40);
      checkPix(0, 0, "clip_col0");
      checkPix(5, 0, "clip_col5");
      checkPix(629, 0, "clip_col629");
      checkPix(630, 3, "clip_col630");
      checkPixH(1279, 3, "clip_col639");
      checkPixH(1280, 0, "clip_hblank");

      $display("[TB] vertical blanking suppresses pixels");
      clearSprites();
      setSprite(0, 470, 100, 1, 1'b1);
      applyStimulus(479);
      checkPix(100, 1, "l479_col100");
      applyStimulus(480);
      checkPix(100, 0, "l480_col100");

      $display("[TB] reset during fetch");
      clearSprites();
      setSprite(0, 45, 100, 1, 1'b1);
      vcount = 10'd49;
      hcount = 11'd1300;
      gotoH(1320);
      checkOutput("fetch_busy", 32'(busy), 1);
      checkOutput("fetch_gen_ra", 32'(bus.gen_ra), 170);
      reset = 1'b1;
      stepClk();
      reset = 1'b0;
      checkOutput("rst2_busy", 32'(busy), 0);
      checkOutput("rst2_pix", 32'(pix_code), 0);
      checkOutput("rst2_ovf", 32'(line_overflow), 0);
      gotoH(0);
      checkOutput("l50_ovf", 32'(line_overflow), 1);
      checkPix(100, 0, "l50_blank");
      gotoH(0);
      checkOutput("l51_ovf", 32'(line_overflow), 0);
      checkPix(99, 0, "l51_col99");
      checkPix(100, 1, "l51_col100");

      $display("[TB] disabled sprite 0 takes no slot");
      clearSprites();
      setSprite(0, 60, 100, 1, 1'b0);
      for (int i = 1; i < 5; i++) setSprite(i, 60, 10 + 20*(i-1), 4 + i, 1'b1);
      applyStimulus(60);
      checkOutput("l60_ovf", 32'(line_overflow), 0);
      checkPix(10, 5, "l60_spr1");
      checkPix(70, 8, "l60_spr4");
      checkPix(100, 0, "l60_disabled");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
